// File: rtl/tf_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tf_pkg                                                 |
// | Description : Twiddle table layout and sequencer state encoding.     |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
package tf_pkg;

    localparam int NUM_STAGES   = 4;
    localparam int TF_WORDS     = 43;
    localparam int TF_LAST_ADDR = 42;

    localparam int STAGE_BASE [NUM_STAGES] = '{0, 1, 5, 21};
    localparam int STAGE_CNT  [NUM_STAGES] = '{1, 4, 16, 22};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } tf_state_t;

endpackage
`default_nettype wire

// File: rtl/tf_addr_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tf_addr_gen                                            |
// | Description : Twiddle ROM address sequencer with valid/stage/last    |
// |               tagging. TF_INV_EN adds an inverse-order traversal.    |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module tf_addr_gen
    import tf_pkg::*;
#(
    parameter int ADDR_ROM_WIDTH = 6,
    parameter int STAGE_WIDTH    = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
`ifdef TF_INV_EN
    input  logic                      inv,
`endif
    input  logic                      ready,
    output logic [ADDR_ROM_WIDTH-1:0] rom_addr,
    output logic                      rom_en,
    output logic                      tf_valid,
    output logic [STAGE_WIDTH-1:0]    tf_stage,
    output logic                      tf_last,
    output logic                      busy,
    output logic                      done
);

    localparam logic [STAGE_WIDTH-1:0] c_STAGE_FIRST = '0;
    localparam logic [STAGE_WIDTH-1:0] c_STAGE_LAST  = STAGE_WIDTH'(NUM_STAGES - 1);

    tf_state_t                  r_state;
    tf_state_t                  w_state_nxt;
    logic [STAGE_WIDTH-1:0]     r_stage;
    logic [ADDR_ROM_WIDTH-1:0]  r_offset;
    logic                       r_tf_valid;
    logic [STAGE_WIDTH-1:0]     r_tf_stage;
    logic                       r_tf_last;

    logic                       w_inv;
    logic                       w_start_inv;
    logic [ADDR_ROM_WIDTH-1:0]  w_base;
    logic [ADDR_ROM_WIDTH-1:0]  w_cnt_m1;
    logic [ADDR_ROM_WIDTH-1:0]  w_addr;
    logic                       w_start;
    logic                       w_issue;
    logic                       w_accept;
    logic                       w_stage_end;
    logic                       w_final_stage;
    logic                       w_last_issue;

`ifdef TF_INV_EN
    logic r_inv;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_inv <= 1'b0;
        end else if (w_start) begin
            r_inv <= inv;
        end
    end

    assign w_inv       = r_inv;
    assign w_start_inv = inv;
`else
    assign w_inv       = 1'b0;
    assign w_start_inv = 1'b0;
`endif

    assign w_base        = ADDR_ROM_WIDTH'(STAGE_BASE[r_stage]);
    assign w_cnt_m1      = ADDR_ROM_WIDTH'(STAGE_CNT[r_stage] - 1);
    // Inverse order walks each stage from its top address downwards.
    assign w_addr        = w_inv ? (w_base + w_cnt_m1 - r_offset) : (w_base + r_offset);
    assign w_stage_end   = (r_offset == w_cnt_m1);
    assign w_final_stage = w_inv ? (r_stage == c_STAGE_FIRST) : (r_stage == c_STAGE_LAST);
    assign w_last_issue  = w_stage_end & w_final_stage;

    assign w_start  = (r_state == IDLE) & start;
    assign w_issue  = (r_state == RUN) & (~r_tf_valid | ready);
    assign w_accept = r_tf_valid & ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (start) w_state_nxt = RUN;
            RUN:     if (w_issue && w_last_issue) w_state_nxt = DRAIN;
            DRAIN:   if (w_accept) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Counters freeze on the final word so rom_addr holds it through DRAIN.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stage  <= '0;
            r_offset <= '0;
        end else if (w_start) begin
            r_stage  <= w_start_inv ? c_STAGE_LAST : c_STAGE_FIRST;
            r_offset <= '0;
        end else if (w_issue && !w_last_issue) begin
            if (w_stage_end) begin
                r_offset <= '0;
                r_stage  <= w_inv ? (r_stage - 1'b1) : (r_stage + 1'b1);
            end else begin
                r_offset <= r_offset + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tf_valid <= 1'b0;
            r_tf_stage <= '0;
            r_tf_last  <= 1'b0;
        end else if (w_issue) begin
            r_tf_valid <= 1'b1;
            r_tf_stage <= r_stage;
            r_tf_last  <= w_last_issue;
        end else if (w_accept) begin
            r_tf_valid <= 1'b0;
        end
    end

    assign rom_en   = w_issue;
    assign rom_addr = w_addr;
    assign tf_valid = r_tf_valid;
    assign tf_stage = r_tf_stage;
    assign tf_last  = r_tf_last;
    assign busy     = (r_state != IDLE);
    assign done     = (r_state == DRAIN) & w_accept;

endmodule
`default_nettype wire

// File: tb/tb_tf_addr_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_tf_addr_gen                                         |
// | Description : Scoreboard bench for tf_addr_gen with a ROM model.     |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module tb_tf_addr_gen;

    logic       clk   = 1'b0;
    logic       rst   = 1'b1;
    logic       start = 1'b0;
    logic       ready = 1'b1;
`ifdef TF_INV_EN
    logic       inv   = 1'b0;
`endif
    logic [5:0] rom_addr;
    logic       rom_en;
    logic       tf_valid;
    logic [1:0] tf_stage;
    logic       tf_last;
    logic       busy;
    logic       done;

    logic [5:0] rom_q = '0;

    typedef struct {
        int addr;
        int stage;
        bit last;
    } exp_t;

    exp_t sb[$];
    exp_t m_e;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   done_cnt = 0;
    bit   toggle_ready = 1'b0;

    logic       p_valid = 1'b0;
    logic       p_ready = 1'b0;
    logic       p_rst   = 1'b1;
    logic [1:0] p_stage = '0;
    logic [5:0] p_q     = '0;

    always #5 clk = ~clk;

    tf_addr_gen #(
        .ADDR_ROM_WIDTH(6),
        .STAGE_WIDTH   (2)
    ) u_dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
`ifdef TF_INV_EN
        .inv     (inv),
`endif
        .ready   (ready),
        .rom_addr(rom_addr),
        .rom_en  (rom_en),
        .tf_valid(tf_valid),
        .tf_stage(tf_stage),
        .tf_last (tf_last),
        .busy    (busy),
        .done    (done)
    );

    // tf_ROM stand-in: registered read, Q holds while IREN is low.
    always @(posedge clk) begin
        if (rom_en) rom_q <= rom_addr;
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    function automatic int stage_of(input int a);
        if (a < 1)  return 0;
        if (a < 5)  return 1;
        if (a < 21) return 2;
        return 3;
    endfunction

    task automatic push_seq(input bit inv_i);
        for (int i = 0; i < 43; i++) begin
            exp_t e;
            e.addr  = inv_i ? 42 - i : i;
            e.stage = stage_of(e.addr);
            e.last  = (i == 42);
            sb.push_back(e);
        end
    endtask

    always @(negedge clk) begin
        if (done) done_cnt++;
        if (!rst && tf_valid && ready) begin
            if (sb.size() == 0) begin
                check("extra_word", 1, 0);
            end else begin
                m_e = sb.pop_front();
                check("q_addr", rom_q, m_e.addr);
                check("q_stage", tf_stage, m_e.stage);
                check("q_last", tf_last, m_e.last);
            end
        end
        if (done) check("done_on_last", tf_valid && ready && tf_last, 1);
        if (!p_rst && !rst && p_valid && !p_ready) begin
            check("hold_valid", tf_valid, 1);
            check("hold_stage", tf_stage, p_stage);
            check("hold_q", rom_q, p_q);
        end
        p_valid <= tf_valid;
        p_ready <= ready;
        p_rst   <= rst;
        p_stage <= tf_stage;
        p_q     <= rom_q;
    end

    // Called at posedge+1; returns at posedge+1 of the cycle after start.
    task automatic start_run(input bit inv_i);
`ifdef TF_INV_EN
        inv = inv_i;
`endif
        start = 1'b1;
        push_seq(inv_i);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_idle(input int bound, input int done_before, input string tag);
        bit idle = 1'b0;
        for (int i = 0; i < bound && !idle; i++) begin
            if (!busy) idle = 1'b1;
            else begin
                if (toggle_ready) ready = ~ready;
                @(posedge clk); #1;
            end
        end
        if (!idle) check({tag, "_idle_timeout"}, 0, 1);
        ready = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        check({tag, "_sb_empty"}, sb.size(), 0);
        check({tag, "_done_once"}, done_cnt - done_before, 1);
    endtask

    task automatic wait_for(input int a, input bit on_q, output bit found);
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            if (on_q ? (tf_valid && rom_q == 6'(a)) : (rom_en && rom_addr == 6'(a)))
                found = 1'b1;
            else begin
                @(posedge clk); #1;
            end
        end
    endtask

    initial begin
        int  db;
        bit  found;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_rom_en", rom_en, 0);
        check("rst_rom_addr", rom_addr, 0);
        check("rst_valid", tf_valid, 0);
        check("rst_stage", tf_stage, 0);
        check("rst_last", tf_last, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Forward run, exact cycle timing; start re-pulsed as DRAIN retires.
        db = done_cnt;
        start_run(1'b0);
        for (int c = 1; c <= 45; c++) begin
            @(negedge clk);
            check("fw_rom_en", rom_en, c <= 43);
            if (c <= 43) check("fw_rom_addr", rom_addr, c - 1);
            check("fw_valid", tf_valid, c >= 2 && c <= 44);
            if (c <= 44) check("fw_last", tf_last, c == 44);
            check("fw_done", done, c == 44);
            check("fw_busy", busy, c <= 44);
            @(posedge clk); #1;
            start = (c + 1 == 44);
        end
        start = 1'b0;
        @(negedge clk);
        check("fw_start_ignored", busy, 0);
        check("fw_sb_empty", sb.size(), 0);
        check("fw_done_once", done_cnt - db, 1);
        @(posedge clk); #1;

        // Backpressure while address 3 sits on Q.
        db = done_cnt;
        start_run(1'b0);
        wait_for(3, 1'b1, found);
        if (!found) check("bp_find_timeout", 0, 1);
        ready = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check("bp_rom_en", rom_en, 0);
            check("bp_rom_addr", rom_addr, 4);
            @(posedge clk); #1;
        end
        ready = 1'b1;
        wait_idle(200, db, "bp");

        // start mid-run is ignored.
        db = done_cnt;
        start_run(1'b0);
        wait_for(10, 1'b0, found);
        if (!found) check("mid_find_timeout", 0, 1);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_idle(200, db, "mid");

        // Reset while address 30 issues, then restart.
        db = done_cnt;
        start_run(1'b0);
        wait_for(30, 1'b0, found);
        if (!found) check("rst_find_timeout", 0, 1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("mrst_rom_en", rom_en, 0);
        check("mrst_rom_addr", rom_addr, 0);
        check("mrst_valid", tf_valid, 0);
        check("mrst_stage", tf_stage, 0);
        check("mrst_last", tf_last, 0);
        check("mrst_busy", busy, 0);
        check("mrst_no_done", done_cnt - db, 0);
        sb.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        start_run(1'b0);
        wait_idle(200, db, "restart");

        // ready toggling every cycle for a whole run.
        db = done_cnt;
        toggle_ready = 1'b1;
        start_run(1'b0);
        wait_idle(300, db, "tog");
        toggle_ready = 1'b0;

`ifdef TF_INV_EN
        db = done_cnt;
        start_run(1'b1);
        wait_idle(200, db, "inv");
        inv = 1'b0;
        db = done_cnt;
        start_run(1'b0);
        wait_idle(200, db, "fwd_after_inv");
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
